// File: rtl/maze_pkg.sv
// Shared definitions for the maze display path: cell codes, geometry and
// frame-buffer FSM encoding used by the display driver and game logic.
package maze_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 2;
  localparam int CELLS  = 64;

  localparam logic [DATA_W-1:0] CELL_EMPTY  = 2'b00;
  localparam logic [DATA_W-1:0] CELL_WALL   = 2'b01;
  localparam logic [DATA_W-1:0] CELL_GOAL   = 2'b10;
  localparam logic [DATA_W-1:0] CELL_PLAYER = 2'b11;

  typedef enum logic {
    FB_IDLE  = 1'b0,
    FB_CLEAR = 1'b1
  } fb_state_t;

endpackage

// File: rtl/maze_frame_buffer_blink_divider.sv
// Free-running blink timebase: phase toggles every BLINK_DIV clock cycles,
// starting visible (phase = 1) out of reset.
module blink_divider #(
  parameter int BLINK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic phase
);

  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             cnt_tc;

  assign cnt_tc = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt_tc) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/maze_frame_buffer.sv
// 8x8 two-bit maze frame store with registered display read port, game write
// port, blinking player overlay and sequential whole-frame clear.
//
// state    | meaning
// ---------+------------------------------------------------------------
// FB_IDLE  | normal operation; game writes accepted, clear request armed
// FB_CLEAR | one cell per cycle written EMPTY, game writes dropped, busy
module maze_frame_buffer
  import maze_pkg::*;
#(
  parameter int BLINK_DIV = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              command,
  output logic [DATA_W-1:0] data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear,
  output logic              busy,
  input  logic              player_en,
  input  logic [ADDR_W-1:0] player_addr
);

  fb_state_t         state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [CELLS];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              blink_phase;
  logic              overlay_hit;

  blink_divider #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .clk   (clk),
    .rst   (rst),
    .phase (blink_phase)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FB_IDLE;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= (state == FB_CLEAR) ? clr_ptr + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FB_IDLE:  if (clear) state_nxt = FB_CLEAR;
      FB_CLEAR: if (clr_ptr == ADDR_W'(CELLS - 1)) state_nxt = FB_IDLE;
      default:  state_nxt = FB_IDLE;
    endcase
  end

  // A clear request takes priority over a game write on the same edge.
  always_comb begin
    busy      = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    case (state)
      FB_IDLE: begin
        mem_we = wr_en & ~clear;
      end
      FB_CLEAR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = clr_ptr;
        mem_wdata = CELL_EMPTY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CELLS; i++) mem[i] <= CELL_EMPTY;
    end else if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Overlay only substitutes the returned code; storage keeps the real cell.
  assign overlay_hit = player_en && (address == player_addr) && blink_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= CELL_EMPTY;
    end else if (command) begin
      data <= overlay_hit ? CELL_PLAYER : mem[address];
    end
  end

endmodule
